// File: rtl/countdown_timer_bcd.sv
// Game countdown timer: prescaled binary countdown with miss penalties, a serial
// double-dabble BCD converter and a multiplexed active-low 7-segment display.
//
// Converter states:
//   state   | meaning
//   S_IDLE  | waiting for a pending value change, then latch it
//   S_SHIFT | one double-dabble adjust+shift per cycle, VAL_W cycles
//   S_DONE  | publish the BCD result and mark the display valid
module countdown_timer_bcd #(
   parameter int TICK_DIV   = 5000,
   parameter int VAL_W      = 24,
   parameter int INIT_VALUE = 1800000,
   parameter int PENALTY    = 10,
   parameter int DIGITS     = 8,
   parameter int DP_POS     = 4,
   parameter int SCAN_DIV   = 2048
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  miss,
   input  logic                  restart,
   output logic                  a,
   output logic                  b,
   output logic                  c,
   output logic                  d,
   output logic                  e,
   output logic                  f,
   output logic                  g,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  game_fail,
   output logic                  running,
   output logic [4*DIGITS-1:0]   bcd_value
);

   localparam int PW  = $clog2(TICK_DIV);
   localparam int DW  = VAL_W + 1;
   localparam int CW  = (VAL_W > 1) ? $clog2(VAL_W) : 1;
   localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW  = $clog2(DIGITS);
   localparam int SRW = 4*DIGITS + VAL_W;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;

   logic [PW-1:0]       presc_q, presc_d;
   logic [VAL_W-1:0]    value_q, value_d;
   logic                game_fail_q, game_fail_d;
   logic                tick;
   logic [DW-1:0]       dec;
   logic                value_chg;

   conv_state_t         state_q;
   logic                pending_q;
   logic [SRW-1:0]      sr_q, sr_adj;
   logic [CW-1:0]       cnt_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic                valid_q;

   logic [SW-1:0]       scan_q;
   logic [IW-1:0]       idx_q;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   zero_above, blank_mask;
   logic                zacc;
   logic [6:0]          seg_dec, segs;

   assign running   = start & ~game_fail_q;
   assign game_fail = game_fail_q;
   assign tick      = running && (presc_q == PW'(TICK_DIV-1));

   always_comb begin
      presc_d     = presc_q;
      value_d     = value_q;
      game_fail_d = game_fail_q;
      dec         = DW'(tick) + ((miss && !game_fail_q) ? DW'(PENALTY) : '0);
      if (running)
         presc_d = tick ? '0 : presc_q + PW'(1);
      if (restart) begin
         value_d     = VAL_W'(INIT_VALUE);
         game_fail_d = 1'b0;
         presc_d     = '0;
      end else if (dec >= {1'b0, value_q}) begin
         // saturate at zero and flag expiry on the same edge
         value_d     = '0;
         game_fail_d = 1'b1;
      end else begin
         value_d = value_q - dec[VAL_W-1:0];
      end
      value_chg = restart || (value_d != value_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q     <= '0;
         value_q     <= VAL_W'(INIT_VALUE);
         game_fail_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         value_q     <= value_d;
         game_fail_q <= game_fail_d;
      end
   end

   always_comb begin
      sr_adj = sr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_q[VAL_W+4*i +: 4] >= 4'd5)
            sr_adj[VAL_W+4*i +: 4] = sr_q[VAL_W+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pending_q <= 1'b1;
         sr_q      <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pending_q) begin
                  sr_q    <= SRW'(value_q);
                  cnt_q   <= CW'(VAL_W-1);
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               sr_q <= sr_adj << 1;
               if (cnt_q == '0)
                  state_q <= S_DONE;
               else
                  cnt_q <= cnt_q - CW'(1);
            end
            S_DONE: begin
               bcd_q   <= sr_q[SRW-1 -: 4*DIGITS];
               valid_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         // a change arriving mid-conversion is queued, not lost
         if (value_chg)
            pending_q <= 1'b1;
         else if (state_q == S_IDLE)
            pending_q <= 1'b0;
      end
   end

   assign bcd_value = bcd_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scan_q <= '0;
         idx_q  <= '0;
      end else if (scan_q == SW'(SCAN_DIV-1)) begin
         scan_q <= '0;
         idx_q  <= (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + IW'(1);
      end else begin
         scan_q <= scan_q + SW'(1);
      end
   end

   always_comb begin
      zacc       = 1'b1;
      zero_above = '0;
      blank_mask = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         zacc          = zacc & (bcd_q[4*i +: 4] == 4'd0);
         zero_above[i] = zacc;
      end
      for (int i = 0; i < DIGITS; i++)
         blank_mask[i] = (i > DP_POS) && zero_above[i];
   end

   assign nib = bcd_q[4*idx_q +: 4];

   always_comb begin
      case (nib)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b0111111;
      endcase
      segs = (!valid_q || blank_mask[idx_q]) ? 7'b1111111 : seg_dec;
   end

   assign {g, f, e, d, c, b, a} = segs;
   assign an = valid_q ? ~(DIGITS'(1) << idx_q) : '1;
   assign dp = !(valid_q && (idx_q == IW'(DP_POS)));

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd: a decimal-arithmetic model checked
// every cycle, plus literal expectations at key points of the game sequence.
module tb_countdown_timer_bcd;

   localparam int TICK_DIV   = 4;
   localparam int VAL_W      = 8;
   localparam int INIT_VALUE = 25;
   localparam int PENALTY    = 10;
   localparam int DIGITS     = 4;
   localparam int DP_POS     = 1;
   localparam int SCAN_DIV   = 2;

   localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   localparam logic [3:0] AN_LIT  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [6:0] SEG_LIT [4] = '{7'h12, 7'h40, 7'h7F, 7'h7F};
   localparam logic       DP_LIT  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   logic clock, reset, start, miss, restart;
   logic a, b, c, d, e, f, g, dp, game_fail, running;
   logic [DIGITS-1:0]   an;
   logic [4*DIGITS-1:0] bcd_value;
   logic [6:0] segs;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // model state: remaining time and display contents as plain integers
   int m_val, m_presc, m_gf, m_pend, m_busy, m_snap, m_bcd, m_valid, m_cyc;
   int t_dec, t_nv, t_ngf, t_np, t_run, t_tick;

   countdown_timer_bcd #(
      .TICK_DIV(TICK_DIV), .VAL_W(VAL_W), .INIT_VALUE(INIT_VALUE),
      .PENALTY(PENALTY), .DIGITS(DIGITS), .DP_POS(DP_POS), .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .miss(miss), .restart(restart),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
      .game_fail(game_fail), .running(running), .bcd_value(bcd_value)
   );

   assign segs = {g, f, e, d, c, b, a};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   always @(posedge clock) begin
      if (reset) begin
         m_val = INIT_VALUE; m_presc = 0; m_gf = 0; m_pend = 1;
         m_busy = 0; m_snap = 0; m_bcd = 0; m_valid = 0; m_cyc = 0;
      end else begin
         t_run  = (start && !m_gf) ? 1 : 0;
         t_tick = (t_run != 0 && m_presc == TICK_DIV-1) ? 1 : 0;
         if (restart) begin
            t_nv = INIT_VALUE; t_ngf = 0; t_np = 0;
         end else begin
            t_dec = t_tick + ((miss && !m_gf) ? PENALTY : 0);
            if (t_dec >= m_val) begin t_nv = 0; t_ngf = 1; end
            else begin t_nv = m_val - t_dec; t_ngf = m_gf; end
            t_np = (t_run != 0) ? ((t_tick != 0) ? 0 : m_presc + 1) : m_presc;
         end
         // converter: snapshot when free, result appears VAL_W+2 edges after the change
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_bcd = m_snap; m_valid = 1; end
         end else if (m_pend != 0) begin
            m_snap = m_val; m_pend = 0; m_busy = VAL_W + 1;
         end
         if (restart || t_nv != m_val) m_pend = 1;
         m_val = t_nv; m_gf = t_ngf; m_presc = t_np; m_cyc++;
      end
   end

   always @(posedge clock) begin
      int idx;
      logic [DIGITS-1:0] exp_an;
      logic [6:0] exp_seg;
      #2;
      if (chk_en) begin
         idx = (m_cyc / SCAN_DIV) % DIGITS;
         exp_an = '1;
         if (m_valid != 0) exp_an[idx] = 1'b0;
         if (m_valid == 0 || (idx > DP_POS && m_bcd < pow10(idx))) exp_seg = 7'h7F;
         else exp_seg = SEG[(m_bcd / pow10(idx)) % 10];
         check("bcd_value", 32'(bcd_value), 32'(to_bcd(m_bcd)));
         check("game_fail", 32'(game_fail), 32'(m_gf));
         check("running",   32'(running),   32'(start && m_gf == 0));
         check("an",        32'(an),        32'(exp_an));
         check("segs",      32'(segs),      32'(exp_seg));
         check("dp",        32'(dp),        32'((m_valid != 0 && idx == DP_POS) ? 0 : 1));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_val(input int v, input int budget);
      int n = 0;
      while (m_val != v && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("wait_val", 32'(m_val), 32'(v));
   endtask

   task automatic pulse_restart(input logic with_miss);
      restart = 1'b1; miss = with_miss;
      step(1);
      restart = 1'b0; miss = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; miss = 1'b0; restart = 1'b0;
      step(1);
      chk_en = 1;
      check("rst_bcd", 32'(bcd_value), 32'h0);
      check("rst_an",  32'(an),        32'hF);
      check("rst_gf",  32'(game_fail), 32'h0);
      step(2);
      reset = 1'b0;
      step(12);
      check("init_bcd", 32'(bcd_value), 32'h0025);

      // first tick on the 4th running cycle, display follows within VAL_W+2
      start = 1'b1;
      step(4);
      check("tick4_val", 32'(m_val), 32'd24);
      check("tick4_run", 32'(running), 32'h1);
      step(10);
      check("tick4_bcd", 32'(bcd_value), 32'h0024);

      // miss penalties and saturation to game_fail
      pulse_restart(1'b0);
      wait_val(24, 20);
      miss = 1'b1; step(1); miss = 1'b0;
      check("miss_val", 32'(m_val), 32'd14);
      wait_val(7, 60);
      miss = 1'b1; step(1); miss = 1'b0;
      check("fail_gf",  32'(game_fail), 32'h1);
      check("fail_run", 32'(running),   32'h0);
      step(4);
      miss = 1'b1; step(1); miss = 1'b0;
      step(20);
      check("fail_hold_gf",  32'(game_fail), 32'h1);
      check("fail_hold_bcd", 32'(bcd_value), 32'h0000);

      // miss coinciding with a tick
      pulse_restart(1'b0);
      wait_val(15, 100);
      step(3);
      miss = 1'b1; step(1); miss = 1'b0;
      check("coinc_val", 32'(m_val), 32'd4);
      check("coinc_gf",  32'(game_fail), 32'h0);

      // pause mid-prescale: value and prescaler hold
      pulse_restart(1'b0);
      step(2);
      start = 1'b0;
      step(20);
      check("pause_bcd", 32'(bcd_value), 32'h0025);
      check("pause_run", 32'(running),   32'h0);
      start = 1'b1;
      step(1);
      check("resume1_val", 32'(m_val), 32'd25);
      step(1);
      check("resume2_val", 32'(m_val), 32'd24);
      step(10);
      check("resume_bcd", 32'(bcd_value), 32'h0024);

      // restart beats a simultaneous miss while failed
      repeat (3) begin
         miss = 1'b1; step(1); miss = 1'b0; step(1);
      end
      check("pre_rst_gf", 32'(game_fail), 32'h1);
      step(25);
      pulse_restart(1'b1);
      check("rst_gf_clr", 32'(game_fail), 32'h0);
      check("rst_run",    32'(running),   32'h1);
      step(10);
      check("rst_bcd25", 32'(bcd_value), 32'h0025);
      check("rst_val23", 32'(m_val),     32'd23);

      // scan with value 5: blanked upper digits, dp on digit 1
      wait_val(5, 200);
      start = 1'b0;
      step(25);
      check("scan_bcd", 32'(bcd_value), 32'h0005);
      for (int k = 0; k < 8; k++) begin
         int ix;
         step(1);
         ix = (m_cyc / SCAN_DIV) % DIGITS;
         check("scan_an",  32'(an),   32'(AN_LIT[ix]));
         check("scan_seg", 32'(segs), 32'(SEG_LIT[ix]));
         check("scan_dp",  32'(dp),   32'(DP_LIT[ix]));
      end

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
Parametrised game countdown timer with a multiplexed 7-segment display. It supersedes the fixed 8-digit, 0.1 ms countdown. Digit count, tick rate, start value and miss penalty are parameters. Adds a synchronous restart, saturating penalty arithmetic, a sequential binary-to-BCD converter in place of divide/modulo, and leading-zero blanking. Sits between the game FSM (start/miss/restart in, game_fail out) and the board display pins.

Parameters:
TICK_DIV, 5000, clock cycles per countdown unit (≥2)
VAL_W, 24, width of binary remaining-time register
INIT_VALUE, 1800000, value loaded on reset/restart (< 10^DIGITS, < 2^VAL_W)
PENALTY, 10, units subtracted per miss pulse
DIGITS, 8, number of display digits (2..8)
DP_POS, 4, digit index whose decimal point is lit
SCAN_DIV, 2048, clock cycles per displayed digit

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; countdown runs while high
miss  in  1  single-cycle pulse; subtract PENALTY
restart  in  1  synchronous reload to INIT_VALUE
a,b,c,d,e,f,g  out  1 each  active-low segments
dp  out  1  active-low decimal point
an  out  DIGITS  active-low one-hot digit enables
game_fail  out  1  sticky; time expired
running  out  1  start && !game_fail
bcd_value  out  4*DIGITS  BCD of remaining time, digit 0 in LSBs

Behaviour:
- Reset (async): value=INIT_VALUE, prescaler=0, game_fail=0, bcd_value=0, converter pending=1, scan counter=0, digit index=0. Outputs are blank until the first conversion completes (an=all 1s while bcd_value is invalid).
- Prescaler: counts 0..TICK_DIV-1 only while running. tick=1 when the prescaler is at TICK_DIV-1 and running; the prescaler then wraps to 0. While start=0 the prescaler holds its count and does not clear.
- Value update per cycle, with dec = (tick?1:0) + (miss&&!game_fail ? PENALTY : 0):
  - if dec ≥ value: value←0 and game_fail←1 on the same edge.
  - else value←value-dec.
  - miss is honoured even when start=0. miss is ignored once game_fail=1.
- restart has priority over tick and miss. It sets value=INIT_VALUE, prescaler=0, game_fail=0 and converter pending=1. It does not clear bcd_value until the new conversion finishes.
- game_fail stays high until reset or restart. value stays 0 while game_fail=1.
- Converter FSM (double-dabble, one bit per cycle):
  - IDLE: if pending, latch value into a shift register, clear pending, go to SHIFT.
  - SHIFT: VAL_W cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left 1. Then go to DONE.
  - DONE: bcd_value←result, mark valid, go to IDLE.
  - Any value change (update or restart) sets pending. A change during SHIFT does not abort; it is converted next.
  - Latency from value change to bcd_value update: VAL_W+2 cycles. Requires TICK_DIV > VAL_W+2 for a tick-accurate display.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..DIGITS-1 and wraps to 0.
  - an[i]=0 only for the current index i.
  - dp=0 only when index==DP_POS.
- Segments: the current nibble is decoded active-low {g,f,e,d,c,b,a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles >9 show dash 0111111.
- Leading-zero blanking: digit i > DP_POS outputs 1111111 if it and all higher digits are zero. Digits ≤ DP_POS are never blanked.
- Width rules: the subtraction compares in VAL_W+1 bits and never underflows. The BCD shift register is 4*DIGITS+VAL_W bits.

Test Plan (TICK_DIV=4, VAL_W=8, INIT_VALUE=25, PENALTY=10, DIGITS=4, DP_POS=1, SCAN_DIV=2):
1. Release reset, start=1 -> value 25→24 on the 4th running cycle. bcd_value=0x0024 within 10 cycles. running=1.
2. At value 24, pulse miss -> value 14 next edge. At value 7, pulse miss -> value 0, game_fail=1, running=0. Further ticks and miss leave value 0.
3. miss coinciding with tick at value 15 -> value 4 (dec=11), game_fail stays 0.
4. Drop start for 20 cycles mid-prescale (prescaler=2) -> value and prescaler hold. Raise start -> next tick after 2 running cycles.
5. Assert restart while game_fail=1, also pulsing miss -> value 25, game_fail 0, prescaler 0. After conversion, bcd_value=0x0025.
6. Value 5, observe scan -> an cycles 1110,1101,1011,0111, 2 cycles each. Digits 3 and 2 output 1111111. Digit 1 shows 0 with dp=0. Digit 0 shows 0010010.
